// File: rtl/pad_up.sv
`timescale 1ns/1ps
// pad_up: bidirectional I/O pad with a weak pull, combinational loopback and a clk-domain filtered receiver.
// Define PAD_SYNC_EN to add the 2-flop synchronizer and FILT_CYCLES stability filter ahead of DOUT_SYNC.
module pad_up #(
  parameter int PULL        = 1,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic DIN,
  input  logic OEN,
  inout  wire  PAD,
  output logic DOUT,
  output logic DOUT_SYNC,
  output logic RISE,
  output logic FALL,
  output logic CONFLICT
);

`ifdef PAD_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  // Without the synchronizer the filter collapses to a plain register of DOUT.
  localparam logic       PULL_LVL  = (PULL != 0);
  localparam int         FILT_EFF  = SYNC_EN ? FILT_CYCLES : 1;
  localparam logic [3:0] FILT_LAST = 4'(FILT_EFF - 1);
  localparam int         CD        = SYNC_EN ? 2 : 1;

  assign PAD = OEN ? 1'bz : DIN;

  if (PULL != 0) begin : g_pullup
    pullup pu_i (PAD);
  end else begin : g_pulldown
    pulldown pd_i (PAD);
  end

  assign DOUT = PAD;

  logic          rx_val;
  logic          cmp_val;
  logic          dout_sync_q, dout_sync_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          conflict_q, conflict_d;
  logic [CD-1:0] din_hist_q, din_hist_d;
  logic [CD-1:0] oen_hist_q, oen_hist_d;
  logic          steady;

`ifdef PAD_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = DOUT;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= PULL_LVL;
      sync2_q <= PULL_LVL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign rx_val  = sync2_q;
  assign cmp_val = sync2_q;
`else
  assign rx_val  = DOUT;
  assign cmp_val = dout_sync_q;
`endif

  // DOUT_SYNC only moves after rx_val has disagreed with it for FILT_EFF consecutive edges.
  always_comb begin
    cnt_d       = '0;
    dout_sync_d = dout_sync_q;
    if (rx_val != dout_sync_q) begin
      if (cnt_q == FILT_LAST) begin
        dout_sync_d = rx_val;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    rise_d = dout_sync_d & ~dout_sync_q;
    fall_d = ~dout_sync_d & dout_sync_q;
  end

  // Contention is only judged once OEN and DIN have been steady across the whole receive pipeline.
  always_comb begin
    din_hist_d[0] = DIN;
    oen_hist_d[0] = OEN;
    for (int i = 1; i < CD; i++) begin
      din_hist_d[i] = din_hist_q[i-1];
      oen_hist_d[i] = oen_hist_q[i-1];
    end
    steady     = !OEN && (oen_hist_q == '0) && (din_hist_q == {CD{DIN}});
    conflict_d = conflict_q | (steady && (cmp_val != din_hist_q[CD-1]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_sync_q <= PULL_LVL;
      cnt_q       <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      conflict_q  <= 1'b0;
      din_hist_q  <= '0;
      oen_hist_q  <= '1;
    end else begin
      dout_sync_q <= dout_sync_d;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      conflict_q  <= conflict_d;
      din_hist_q  <= din_hist_d;
      oen_hist_q  <= oen_hist_d;
    end
  end

  assign DOUT_SYNC = dout_sync_q;
  assign RISE      = rise_q;
  assign FALL      = fall_q;
  assign CONFLICT  = conflict_q;

endmodule

// File: tb/tb_pad_up.sv
`timescale 1ns/1ps
// tb_pad_up: randomized pad traffic checked every cycle against a history-based model, plus directed pad pairs,
// glitch filtering, contention and mid-filter reset cases. Works with or without PAD_SYNC_EN.
module tb_pad_up;

  localparam int FILT = 4;
`ifdef PAD_SYNC_EN
  localparam int DS_DELAY = 2;
  localparam int FW       = FILT;
  localparam int CD       = 2;
`else
  localparam int DS_DELAY = 0;
  localparam int FW       = 1;
  localparam int CD       = 1;
`endif
  localparam int LAT = DS_DELAY + FW;

  logic clk = 1'b0;
  logic rst;
  logic din, oen, ext_en, ext_val;
  wire  pad_net;
  logic dout, dout_sync, rise, fall, conflict;

  logic din_a, oen_a, din_b, oen_b, din_c, oen_c, din_d, oen_d;
  wire  net_ab, net_cd;
  logic dout_a, ds_a, rise_a, fall_a, conf_a;
  logic dout_b, ds_b, rise_b, fall_b, conf_b;
  logic dout_c, ds_c, rise_c, fall_c, conf_c;
  logic dout_d, ds_d, rise_d, fall_d, conf_d;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  assign pad_net = ext_en ? ext_val : 1'bz;

  pad_up #(.PULL(1), .FILT_CYCLES(FILT)) dut (
    .clk(clk), .rst(rst), .DIN(din), .OEN(oen), .PAD(pad_net),
    .DOUT(dout), .DOUT_SYNC(dout_sync), .RISE(rise), .FALL(fall), .CONFLICT(conflict));

  pad_up #(.PULL(1), .FILT_CYCLES(FILT)) u_a (
    .clk(clk), .rst(rst), .DIN(din_a), .OEN(oen_a), .PAD(net_ab),
    .DOUT(dout_a), .DOUT_SYNC(ds_a), .RISE(rise_a), .FALL(fall_a), .CONFLICT(conf_a));
  pad_up #(.PULL(1), .FILT_CYCLES(FILT)) u_b (
    .clk(clk), .rst(rst), .DIN(din_b), .OEN(oen_b), .PAD(net_ab),
    .DOUT(dout_b), .DOUT_SYNC(ds_b), .RISE(rise_b), .FALL(fall_b), .CONFLICT(conf_b));
  pad_up #(.PULL(0), .FILT_CYCLES(FILT)) u_c (
    .clk(clk), .rst(rst), .DIN(din_c), .OEN(oen_c), .PAD(net_cd),
    .DOUT(dout_c), .DOUT_SYNC(ds_c), .RISE(rise_c), .FALL(fall_c), .CONFLICT(conf_c));
  pad_up #(.PULL(0), .FILT_CYCLES(FILT)) u_d (
    .clk(clk), .rst(rst), .DIN(din_d), .OEN(oen_d), .PAD(net_cd),
    .DOUT(dout_d), .DOUT_SYNC(ds_d), .RISE(rise_d), .FALL(fall_d), .CONFLICT(conf_d));

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-edge history of resolved pad value, OEN and DIN since the last reset.
  typedef struct {
    logic p;
    logic oen;
    logic din;
  } rec_t;

  rec_t hist[$];
  logic m_ds, m_rise, m_fall, m_conf;

  function automatic logic pad_exp();
    if (ext_en) return ext_val;
    if (!oen)   return din;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_ds   = 1'b1;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_conf = 1'b0;
  endtask

  task automatic model_step();
    rec_t r;
    int   n;
    bit   flip;
    bit   stable;
    r.p   = pad_exp();
    r.oen = oen;
    r.din = din;
    hist.push_back(r);
    if (hist.size() > 32) void'(hist.pop_front());
    n = hist.size();
    // The filtered value flips once FW consecutive delayed pad samples all disagree with it.
    flip = (n >= DS_DELAY + FW);
    for (int i = 0; i < FW; i++)
      if (flip && hist[n-1-DS_DELAY-i].p == m_ds) flip = 1'b0;
    m_rise = flip && !m_ds;
    m_fall = flip && m_ds;
    if (flip) m_ds = !m_ds;
    if (n >= CD + 1) begin
      stable = 1'b1;
      for (int i = 0; i <= CD; i++)
        if (hist[n-1-i].oen || hist[n-1-i].din != din) stable = 1'b0;
      if (stable && hist[n-1-CD].p != din) m_conf = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("dout",      dout,      pad_exp());
      check("dout_sync", dout_sync, m_ds);
      check("rise",      rise,      m_rise);
      check("fall",      fall,      m_fall);
      check("conflict",  conflict,  m_conf);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; oen = 1'b1; ext_en = 1'b0; ext_val = 1'b0;
    din_a = 1'b0; oen_a = 1'b1; din_b = 1'b0; oen_b = 1'b1;
    din_c = 1'b0; oen_c = 1'b1; din_d = 1'b0; oen_d = 1'b1;
    #1;
    check("dout_pull_in_rst",    dout,   1'b1);
    check("idle_pullup_pair",    dout_b, 1'b1);
    check("idle_pulldown_pair",  dout_d, 1'b0);
    cycles(2);
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    check("rst_dout_sync",   dout_sync, 1'b1);
    check("rst_rise",        rise,      1'b0);
    check("rst_fall",        fall,      1'b0);
    check("rst_conflict",    conflict,  1'b0);
    check("rst_ds_pullup",   ds_a & ds_b, 1'b1);
    check("rst_ds_pulldown", ds_c | ds_d, 1'b0);
    check("rst_pulses_pair", rise_a | fall_a | conf_a | rise_b | fall_b | conf_b |
                             rise_c | fall_c | conf_c | rise_d | fall_d | conf_d, 1'b0);

    // Linked pads: the released side follows the driving side immediately.
    oen_a = 1'b0; din_a = 1'b0; #1 check("ab_fwd_0", dout_b, 1'b0);
    #19 din_a = 1'b1;           #1 check("ab_fwd_1", dout_b, 1'b1);
    #19 oen_a = 1'b1; oen_b = 1'b0; din_b = 1'b0; #1 check("ba_rev_0", dout_a, 1'b0);
    #19 din_b = 1'b1;           #1 check("ba_rev_1", dout_a, 1'b1);
    #19 oen_b = 1'b1;           #1 check("ab_released", dout_a, 1'b1);
    oen_c = 1'b0; din_c = 1'b1; #1 check("cd_fwd_1", dout_d, 1'b1);
    #19 din_c = 1'b0;           #1 check("cd_fwd_0", dout_d, 1'b0);
    #19 oen_c = 1'b1; oen_d = 1'b0; din_d = 1'b1; #1 check("dc_rev_1", dout_c, 1'b1);
    #19 din_d = 1'b0;           #1 check("dc_rev_0", dout_c, 1'b0);
    #19 oen_d = 1'b1;           #1 check("cd_released", dout_c, 1'b0);
    @(posedge clk); #2;

`ifdef PAD_SYNC_EN
    ext_en = 1'b1; ext_val = 1'b0;
    cycles(2);
    ext_en = 1'b0;
    cycles(8);
    @(negedge clk);
    check("glitch_ignored", dout_sync, 1'b1);
    @(posedge clk); #2;
`endif

    // Long external low on the released pull-up pad, then release.
    ext_en = 1'b1; ext_val = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check("low_not_yet",  dout_sync, 1'b1);
    @(negedge clk);
    check("low_taken",    dout_sync, 1'b0);
    check("fall_pulse",   fall,      1'b1);
    @(negedge clk);
    check("fall_one_cyc", fall,      1'b0);
    repeat (10 - (LAT + 1)) @(posedge clk);
    #2 ext_en = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check("high_not_yet", dout_sync, 1'b0);
    @(negedge clk);
    check("high_taken",   dout_sync, 1'b1);
    check("rise_pulse",   rise,      1'b1);
    cycles(3);

    // Reset partway through filtering a low level.
    ext_en = 1'b1; ext_val = 1'b0;
    cycles(4);
    rst = 1'b1;
    #1;
    check("midrst_dout_sync", dout_sync, 1'b1);
    check("midrst_fall",      fall,      1'b0);
    ext_en = 1'b0;
    cycles(1);
    rst = 1'b0;
    cycles(LAT + 4);

    // Contention: local drive 0 against an external strong 1.
    oen = 1'b0; din = 1'b0;
    cycles(4);
    @(negedge clk);
    check("no_conflict_steady", conflict, 1'b0);
    @(posedge clk); #2;
    check_en = 1'b0;
    ext_en = 1'b1; ext_val = 1'b1;
    cycles(5);
    @(negedge clk);
    check("conflict_set", conflict, 1'b1);
    @(posedge clk); #2;
    ext_en = 1'b0;
    cycles(4);
    @(negedge clk);
    check("conflict_sticky", conflict, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check("conflict_cleared", conflict, 1'b0);
    oen = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_en = 1'b1;

    for (int seg = 0; seg < 80; seg++) begin
      int len;
      len = $urandom_range(1, 12);
      oen = 1'($urandom_range(0, 1));
      din = 1'($urandom_range(0, 1));
      if (oen) begin
        ext_en  = 1'($urandom_range(0, 1));
        ext_val = 1'($urandom_range(0, 1));
      end else begin
        ext_en = 1'b0;
      end
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) din = 1'($urandom_range(0, 1));
        cycles(1);
      end
    end

    cycles(2);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
